demux8_buf: RTL and testbench
=============================

Name: demux8_buf

Overview:
- 1-to-8 buffered demultiplexer: the write-side counterpart of the 8-way select path.
- Accepts one 32-bit word per cycle on a valid/ready input together with a 3-bit destination select.
- Queues the word in the selected lane's FIFO; each lane presents it to its consumer on an independent valid/ready output.
- Sits between a single result producer (e.g. execute/writeback) and up to eight consumers (register write port, CSR unit, LSU, debug tap, ...).

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per lane FIFO; power of two, minimum 2.
- AW, 1, log2(DEPTH); derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  word will be accepted this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  3  destination lane 0..7.
- out_valid  output  8  bit k: lane k head valid.
- out_ready  input  8  bit k: consumer k takes head.
- out_data  output  8*WIDTH  lane k head at bits [k*WIDTH +: WIDTH].
- lane_full  output  8  bit k: lane k holds DEPTH entries.
- idle  output  1  all lanes empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All lane read/write pointers and counts go to 0.
  - out_valid = 0, lane_full = 0, idle = 1, in_ready = 1.
  - out_data = 0; storage contents need not be cleared, but out_data must read 0 while a lane is empty.
- Reset asserted mid-transfer discards all queued words. No handshake completes in the cycle reset is released.
- Push: when in_valid && in_ready at a rising clk edge, in_data is written at the write pointer of lane in_sel, then that pointer and count increment. Pointers wrap modulo DEPTH.
- in_ready = !lane_full[in_sel]. It depends only on registered state and in_sel; there is no combinational path from out_ready to in_ready.
- Head-of-line blocking is intended: a full selected lane stalls the input even when other lanes are empty.
  - in_sel and in_data must stay stable while in_valid is high and in_ready is low.
- Pop: lane k pops when out_valid[k] && out_ready[k]. Its read pointer increments with wrap and its count decrements.
- out_valid[k] = (count_k != 0). out_data lane k = storage at read pointer k.
  - Both are driven from registered state; latency is 1 cycle from an accepted push to out_valid.
- Simultaneous push and pop on the same lane:
  - Both happen and the count is unchanged.
  - This is permitted only when the lane is not full, because in_ready is low when full. A full lane therefore needs one pop cycle before the next push.
- Simultaneous pops on several lanes and a push to another lane are all independent and occur in the same cycle.
- An empty lane ignores out_ready; no count underflow.
- lane_full[k] = (count_k == DEPTH). idle = all counts zero.
- Counts are AW+1 bits wide.
- Per-lane ordering is FIFO. There is no ordering guarantee across lanes.
- Data passes through unmodified; no width conversion.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-stream with lanes 2 and 5 holding words.
  - Required: immediately out_valid=8'h00, idle=1, in_ready=1, out_data all zero.
  - After release: first push to lane 2 of 32'hA5A5_0001 appears alone on lane 2 one cycle later.
- Routing:
  - Stimulus: push 32'h0000_0010+k with in_sel=k for k=0..7 on consecutive cycles, all out_ready=0.
  - Required: out_valid=8'hFF after 8 cycles; lane k shows 32'h0000_0010+k; idle=0.
- Full/backpressure (DEPTH=2):
  - Stimulus: push 32'h11, 32'h22, 32'h33 to lane 3 with out_ready=0.
  - Required: in_ready drops after the second accept; lane_full=8'h08; 32'h33 is held.
  - Stimulus: raise out_ready[3] for 1 cycle.
  - Required: 32'h11 pops, 32'h33 is accepted the next cycle, and the lane drains 22 then 33 in order.
- Simultaneous push/pop with wrap:
  - Stimulus: lane 6 holds 1 word; push 32'hBEEF while out_ready[6]=1, repeated 10 cycles with incrementing data.
  - Required: count stays 1 and each word appears exactly one cycle after its push, across multiple pointer wraps.
- Head-of-line blocking:
  - Stimulus: fill lane 0; then present in_sel=1.
  - Required: in_ready=0 while in_sel=0 is held; when in_sel switches to 1 with lane 0 still full, in_ready=1 and the word enters lane 1.
- Random soak:
  - Stimulus: 10k cycles of random in_valid/in_sel/out_ready.
  - Required: a per-lane scoreboard matches order and data, no word is lost or duplicated, and idle=1 once all lanes have drained.

Source files
------------

// File: rtl/demux8_buf_if.sv
// ---------------------------------------------------------------------------
// demux8_buf_if
// Bus bundle between a single word producer, the demux8_buf block and up to
// eight downstream consumers.
//
//   in_valid   producer has a word
//   in_ready   block will accept the word this cycle
//   in_data    word to route
//   in_sel     destination lane 0..7
//   out_valid  bit k: lane k head is valid
//   out_ready  bit k: consumer k takes the head of lane k
//   out_data   lane k head at bits [k*WIDTH +: WIDTH]
//
// master: the environment (producer + consumers)
// slave : the demux8_buf block
// ---------------------------------------------------------------------------
interface demux8_buf_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [2:0]         in_sel;
    logic [7:0]         out_valid;
    logic [7:0]         out_ready;
    logic [8*WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux8_buf.sv
// ---------------------------------------------------------------------------
// demux8_buf
// 1-to-8 buffered demultiplexer. One word per cycle enters on a valid/ready
// input together with a destination select and is queued in that lane's
// FIFO. Each lane presents its head to its own consumer on an independent
// valid/ready output. Per-lane order is FIFO; lanes are independent.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        demux8_buf_if slave modport (input handshake + 8 output lanes)
//   lane_full  bit k: lane k holds DEPTH entries
//   idle       all lanes empty
//
// Parameters:
//   WIDTH  data word width
//   DEPTH  entries per lane FIFO (power of two, >= 2)
// ---------------------------------------------------------------------------
module demux8_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    demux8_buf_if.slave      bus,
    output logic [7:0]       lane_full,
    output logic             idle
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem    [8][DEPTH];
    logic [AW-1:0]    wr_ptr [8];
    logic [AW-1:0]    rd_ptr [8];
    logic [AW:0]      count  [8];

    logic [7:0]       push_lane;
    logic [7:0]       pop_lane;
    logic             push;

    // Accept depends only on the registered fullness of the selected lane,
    // so a full selected lane stalls the input even if others are empty
    // (intended head-of-line blocking) and out_ready never reaches in_ready.
    always_comb begin
        bus.in_ready = !lane_full[bus.in_sel];
        push         = bus.in_valid && bus.in_ready;
        push_lane    = '0;
        pop_lane     = '0;
        for (int k = 0; k < 8; k++) begin
            push_lane[k] = push && (bus.in_sel == 3'(k));
            pop_lane[k]  = (count[k] != '0) && bus.out_ready[k];
        end
    end

    // Lane status and head presentation come straight from registered state.
    // An empty lane drives zero data rather than stale storage.
    always_comb begin
        bus.out_valid = '0;
        bus.out_data  = '0;
        lane_full     = '0;
        idle          = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.out_valid[k] = (count[k] != '0);
            lane_full[k]     = (count[k] == (AW+1)'(DEPTH));
            if (count[k] != '0) begin
                bus.out_data[k*WIDTH +: WIDTH] = mem[k][rd_ptr[k]];
                idle = 1'b0;
            end
        end
    end

    // Pointer and occupancy bookkeeping. Pointers wrap naturally because
    // DEPTH is a power of two. A push and pop in the same cycle on one lane
    // leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (push_lane[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + AW'(1);
                end
                if (pop_lane[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + AW'(1);
                end
                case ({push_lane[k], pop_lane[k]})
                    2'b10:   count[k] <= count[k] + (AW+1)'(1);
                    2'b01:   count[k] <= count[k] - (AW+1)'(1);
                    default: count[k] <= count[k];
                endcase
            end
        end
    end

    // Word storage carries no reset; empty lanes are masked on the output.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[bus.in_sel][wr_ptr[bus.in_sel]] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_demux8_buf.sv
// ---------------------------------------------------------------------------
// tb_demux8_buf
// Directed and random self-checking bench for demux8_buf (WIDTH=32, DEPTH=2).
// ---------------------------------------------------------------------------
module tb_demux8_buf;
    logic       clk;
    logic       rst_n;
    logic [7:0] lane_full;
    logic       idle;
    int         pass_cnt;
    int         total_cnt;

    // Random-soak reference model: two slots per lane, slot 0 is the head.
    logic [31:0] mdl_e [8][2];
    int          mdl_c [8];

    demux8_buf_if #(.WIDTH(32)) bus ();

    demux8_buf #(.WIDTH(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .lane_full (lane_full),
        .idle      (idle)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout reached, run did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_sel    = 3'd0;
        bus.in_data   = 32'h0;
        bus.out_ready = 8'h00;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        total_cnt++; if (bus.out_valid !== 8'h00) $display("[TB] FAIL por_valid got %h exp 00", bus.out_valid); else pass_cnt++;
        total_cnt++; if (idle !== 1'b1) $display("[TB] FAIL por_idle got %b exp 1", idle); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL por_ready got %b exp 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (lane_full !== 8'h00) $display("[TB] FAIL por_full got %h exp 00", lane_full); else pass_cnt++;
        rst_n = 1'b1;
        tick();
        // load lanes 2 and 5
        bus.in_valid = 1'b1; bus.in_sel = 3'd2; bus.in_data = 32'h2222_0002;
        tick();
        bus.in_sel = 3'd5; bus.in_data = 32'h5555_0005;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.out_valid !== 8'h24) $display("[TB] FAIL pre_rst_valid got %h exp 24", bus.out_valid); else pass_cnt++;
        // assert reset mid-stream between edges
        rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.out_valid !== 8'h00) $display("[TB] FAIL rst_valid got %h exp 00", bus.out_valid); else pass_cnt++;
        total_cnt++; if (idle !== 1'b1) $display("[TB] FAIL rst_idle got %b exp 1", idle); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL rst_ready got %b exp 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.out_data !== 256'h0) $display("[TB] FAIL rst_data got %h exp 0", bus.out_data); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b1; bus.in_sel = 3'd2; bus.in_data = 32'hA5A5_0001;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.out_valid !== 8'h04) $display("[TB] FAIL post_rst_valid got %h exp 04", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.out_data !== {160'h0, 32'hA5A5_0001, 64'h0}) $display("[TB] FAIL post_rst_data got %h exp lane2=A5A50001 only", bus.out_data); else pass_cnt++;
        bus.out_ready = 8'h04;
        tick();
        bus.out_ready = 8'h00;
        total_cnt++; if (idle !== 1'b1) $display("[TB] FAIL post_rst_drain_idle got %b exp 1", idle); else pass_cnt++;
    endtask

    task automatic test_routing();
        idle_inputs();
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 3'(k);
            bus.in_data  = 32'h0000_0010 + 32'(k);
            #1;
            total_cnt++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL route_ready lane %0d got %b exp 1", k, bus.in_ready); else pass_cnt++;
            tick();
        end
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.out_valid !== 8'hFF) $display("[TB] FAIL route_valid got %h exp FF", bus.out_valid); else pass_cnt++;
        total_cnt++; if (idle !== 1'b0) $display("[TB] FAIL route_idle got %b exp 0", idle); else pass_cnt++;
        total_cnt++; if (lane_full !== 8'h00) $display("[TB] FAIL route_full got %h exp 00", lane_full); else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            total_cnt++; if (bus.out_data[k*32 +: 32] !== 32'h0000_0010 + 32'(k)) $display("[TB] FAIL route_data lane %0d got %h exp %h", k, bus.out_data[k*32 +: 32], 32'h10 + 32'(k)); else pass_cnt++;
        end
        bus.out_ready = 8'hFF;
        tick();
        bus.out_ready = 8'h00;
        total_cnt++; if (idle !== 1'b1) $display("[TB] FAIL route_drain_idle got %b exp 1", idle); else pass_cnt++;
    endtask

    task automatic test_full();
        idle_inputs();
        bus.in_valid = 1'b1; bus.in_sel = 3'd3; bus.in_data = 32'h11;
        tick();
        bus.in_data = 32'h22;
        tick();
        bus.in_data = 32'h33;
        #1;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL full_ready got %b exp 0", bus.in_ready); else pass_cnt++;
        total_cnt++; if (lane_full !== 8'h08) $display("[TB] FAIL full_mask got %h exp 08", lane_full); else pass_cnt++;
        tick();
        total_cnt++; if (bus.out_data[3*32 +: 32] !== 32'h11) $display("[TB] FAIL full_hold_head got %h exp 11", bus.out_data[3*32 +: 32]); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL full_hold_ready got %b exp 0", bus.in_ready); else pass_cnt++;
        bus.out_ready = 8'h08;
        tick();
        bus.out_ready = 8'h00;
        total_cnt++; if (bus.out_data[3*32 +: 32] !== 32'h22) $display("[TB] FAIL full_pop_head got %h exp 22", bus.out_data[3*32 +: 32]); else pass_cnt++;
        total_cnt++; if (lane_full !== 8'h00) $display("[TB] FAIL full_pop_mask got %h exp 00", lane_full); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL full_pop_ready got %b exp 1", bus.in_ready); else pass_cnt++;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++; if (lane_full !== 8'h08) $display("[TB] FAIL full_refill_mask got %h exp 08", lane_full); else pass_cnt++;
        bus.out_ready = 8'h08;
        tick();
        total_cnt++; if (bus.out_data[3*32 +: 32] !== 32'h33) $display("[TB] FAIL full_drain_33 got %h exp 33", bus.out_data[3*32 +: 32]); else pass_cnt++;
        tick();
        bus.out_ready = 8'h00;
        total_cnt++; if (bus.out_valid !== 8'h00) $display("[TB] FAIL full_drained got %h exp 00", bus.out_valid); else pass_cnt++;
    endtask

    task automatic test_push_pop_wrap();
        idle_inputs();
        bus.in_valid = 1'b1; bus.in_sel = 3'd6; bus.in_data = 32'h1000;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.in_data   = 32'hBEEF + 32'(i);
            bus.out_ready = 8'h40;
            tick();
            total_cnt++; if (bus.out_valid !== 8'h40) $display("[TB] FAIL pp_valid iter %0d got %h exp 40", i, bus.out_valid); else pass_cnt++;
            total_cnt++; if (bus.out_data[6*32 +: 32] !== 32'hBEEF + 32'(i)) $display("[TB] FAIL pp_data iter %0d got %h exp %h", i, bus.out_data[6*32 +: 32], 32'hBEEF + 32'(i)); else pass_cnt++;
            total_cnt++; if (lane_full !== 8'h00) $display("[TB] FAIL pp_full iter %0d got %h exp 00", i, lane_full); else pass_cnt++;
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 8'h00;
        total_cnt++; if (bus.out_valid !== 8'h00) $display("[TB] FAIL pp_drained got %h exp 00", bus.out_valid); else pass_cnt++;
    endtask

    task automatic test_hol_blocking();
        idle_inputs();
        bus.in_valid = 1'b1; bus.in_sel = 3'd0; bus.in_data = 32'hA0;
        tick();
        bus.in_data = 32'hA1;
        tick();
        bus.in_data = 32'hA2;
        #1;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL hol_blocked got %b exp 0", bus.in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (bus.out_valid !== 8'h01) $display("[TB] FAIL hol_valid got %h exp 01", bus.out_valid); else pass_cnt++;
        bus.in_sel = 3'd1; bus.in_data = 32'h1111;
        #1;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL hol_switch_ready got %b exp 1", bus.in_ready); else pass_cnt++;
        tick();
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.out_valid !== 8'h03) $display("[TB] FAIL hol_lane1_valid got %h exp 03", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.out_data[1*32 +: 32] !== 32'h1111) $display("[TB] FAIL hol_lane1_data got %h exp 1111", bus.out_data[1*32 +: 32]); else pass_cnt++;
        total_cnt++; if (bus.out_data[0 +: 32] !== 32'hA0) $display("[TB] FAIL hol_lane0_head got %h exp A0", bus.out_data[0 +: 32]); else pass_cnt++;
        bus.out_ready = 8'hFF;
        tick();
        tick();
        bus.out_ready = 8'h00;
        total_cnt++; if (idle !== 1'b1) $display("[TB] FAIL hol_drain_idle got %b exp 1", idle); else pass_cnt++;
    endtask

    task automatic test_soak();
        logic [7:0]   exp_valid;
        logic [7:0]   exp_full;
        logic [255:0] exp_data;
        logic         exp_ready;
        logic [31:0]  next_word;
        int           sel;
        idle_inputs();
        for (int k = 0; k < 8; k++) mdl_c[k] = 0;
        next_word = 32'hC000_0000;
        for (int cyc = 0; cyc < 10004; cyc++) begin
            if (cyc < 10000) begin
                bus.in_valid  = ($urandom_range(0, 9) < 7);
                bus.in_sel    = 3'($urandom_range(0, 7));
                bus.in_data   = next_word;
                bus.out_ready = 8'($urandom);
            end else begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 8'hFF;
            end
            #1;
            exp_valid = '0; exp_full = '0; exp_data = '0;
            for (int k = 0; k < 8; k++) begin
                exp_valid[k] = (mdl_c[k] != 0);
                exp_full[k]  = (mdl_c[k] == 2);
                if (mdl_c[k] != 0) exp_data[k*32 +: 32] = mdl_e[k][0];
            end
            sel       = int'(bus.in_sel);
            exp_ready = (mdl_c[sel] < 2);
            total_cnt++; if (bus.in_ready !== exp_ready) $display("[TB] FAIL soak_ready cyc %0d got %b exp %b", cyc, bus.in_ready, exp_ready); else pass_cnt++;
            total_cnt++; if (bus.out_valid !== exp_valid) $display("[TB] FAIL soak_valid cyc %0d got %h exp %h", cyc, bus.out_valid, exp_valid); else pass_cnt++;
            total_cnt++; if (bus.out_data !== exp_data) $display("[TB] FAIL soak_data cyc %0d got %h exp %h", cyc, bus.out_data, exp_data); else pass_cnt++;
            total_cnt++; if (lane_full !== exp_full) $display("[TB] FAIL soak_full cyc %0d got %h exp %h", cyc, lane_full, exp_full); else pass_cnt++;
            // model update: pops first, then the accepted push
            for (int k = 0; k < 8; k++) begin
                if (mdl_c[k] != 0 && bus.out_ready[k]) begin
                    mdl_e[k][0] = mdl_e[k][1];
                    mdl_c[k]    = mdl_c[k] - 1;
                end
            end
            if (bus.in_valid && exp_ready) begin
                mdl_e[sel][mdl_c[sel]] = bus.in_data;
                mdl_c[sel] = mdl_c[sel] + 1;
                next_word  = next_word + 32'd1;
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 8'h00;
        total_cnt++; if (idle !== 1'b1) $display("[TB] FAIL soak_final_idle got %b exp 1", idle); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 8'h00) $display("[TB] FAIL soak_final_valid got %h exp 00", bus.out_valid); else pass_cnt++;
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        idle_inputs();
        $display("[TB] demux8_buf bench start");
        test_reset();
        test_routing();
        test_full();
        test_push_pop_wrap();
        test_hol_blocking();
        test_soak();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
